// File: rtl/time_scale_mtrig_pkg.sv
// Shared types and constants for the time scale with multi-channel capture.
// Load scheduling modes and the nominal seconds-per-week wrap.
package time_scale_mtrig_pkg;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'd0,
        AT_EPOCH  = 2'd1,
        AT_SEC    = 2'd2
    } set_mode_e;

    localparam int SEC_IN_WEEK = 604800;

endpackage

// File: rtl/ts_capture_ch.sv
// One timestamp capture channel with sticky valid/overflow flags.
// A clear coincident with a trigger takes the fresh capture.
module ts_capture_ch #(
    parameter int CHIP_W  = 20,
    parameter int EPOCH_W = 10,
    parameter int SEC_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic               trig_clr,
    input  logic [CHIP_W-1:0]  chip,
    input  logic [EPOCH_W-1:0] epoch,
    input  logic [SEC_W-1:0]   sec,
    output logic               cap_valid,
    output logic               cap_ovf,
    output logic [CHIP_W-1:0]  cap_chip,
    output logic [EPOCH_W-1:0] cap_epoch,
    output logic [SEC_W-1:0]   cap_sec
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_ovf   <= 1'b0;
            cap_chip  <= '0;
            cap_epoch <= '0;
            cap_sec   <= '0;
        end else if (trig && (!cap_valid || trig_clr)) begin
            cap_valid <= 1'b1;
            cap_ovf   <= 1'b0;
            cap_chip  <= chip;
            cap_epoch <= epoch;
            cap_sec   <= sec;
        end else if (trig_clr) begin
            cap_valid <= 1'b0;
            cap_ovf   <= 1'b0;
        end else if (trig) begin
            cap_ovf   <= 1'b1;
        end
    end

endmodule

// File: rtl/time_scale_mtrig.sv
// Chip/epoch/second/week timescale with scheduled loads, N capture
// channels and a programmable PPS output.
module time_scale_mtrig
    import time_scale_mtrig_pkg::*;
#(
    parameter int CHIP_W        = 20,
    parameter int EPOCH_W       = 10,
    parameter int SEC_W         = 20,
    parameter int SEC_WRAP      = SEC_IN_WEEK,
    parameter int N_TRIG        = 4,
    parameter int CHIP_MAX_RST  = 1023,
    parameter int EPOCH_MAX_RST = 999,
    parameter int PPS_LEN_W     = 7,
    parameter int PPS_MIN_CLK   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_req,
    input  logic [1:0]                 set_mode,
    input  logic [CHIP_W-1:0]          set_chip,
    input  logic [EPOCH_W-1:0]         set_epoch,
    input  logic [SEC_W-1:0]           set_sec,
    input  logic [CHIP_W-1:0]          set_chip_max,
    input  logic [EPOCH_W-1:0]         set_epoch_max,
    output logic                       set_pending,
    output logic [CHIP_W-1:0]          chip,
    output logic [EPOCH_W-1:0]         epoch,
    output logic [SEC_W-1:0]           sec,
    output logic                       epoch_pulse,
    output logic                       sec_pulse,
    output logic                       week_pulse,
    input  logic [N_TRIG-1:0]          trig,
    input  logic [N_TRIG-1:0]          trig_clr,
    output logic [N_TRIG-1:0]          cap_valid,
    output logic [N_TRIG-1:0]          cap_ovf,
    output logic [N_TRIG*CHIP_W-1:0]   cap_chip,
    output logic [N_TRIG*EPOCH_W-1:0]  cap_epoch,
    output logic [N_TRIG*SEC_W-1:0]    cap_sec,
    input  logic [26:0]                pps_dly,
    input  logic [PPS_LEN_W-1:0]       pps_len,
    output logic                       pps_out
);

    localparam int MIN_W = $clog2(PPS_MIN_CLK + 1);

    logic [CHIP_W-1:0]  chip_max;
    logic [EPOCH_W-1:0] epoch_max;

    logic [CHIP_W-1:0]  pend_chip;
    logic [EPOCH_W-1:0] pend_epoch;
    logic [SEC_W-1:0]   pend_sec;
    logic [CHIP_W-1:0]  pend_chip_max;
    logic [EPOCH_W-1:0] pend_epoch_max;
    set_mode_e          pend_mode;
    set_mode_e          req_mode;

    logic req_imm;
    logic apply_sched;
    logic apply;

    assign epoch_pulse = (chip == chip_max);
    assign sec_pulse   = epoch_pulse && (epoch == epoch_max);
    assign week_pulse  = sec_pulse && (sec == SEC_W'(SEC_WRAP - 1));

    assign req_mode = set_mode_e'(set_mode);
    assign req_imm  = set_req && !(req_mode == AT_EPOCH || req_mode == AT_SEC);

    // A request arriving this cycle supersedes any strobe-triggered apply.
    assign apply_sched = set_pending && !set_req &&
                         ((pend_mode == AT_EPOCH && epoch_pulse) ||
                          (pend_mode == AT_SEC   && sec_pulse));
    assign apply = req_imm || apply_sched;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_pending    <= 1'b0;
            pend_mode      <= IMMEDIATE;
            pend_chip      <= '0;
            pend_epoch     <= '0;
            pend_sec       <= '0;
            pend_chip_max  <= '0;
            pend_epoch_max <= '0;
        end else if (set_req) begin
            set_pending    <= !req_imm;
            pend_mode      <= req_mode;
            pend_chip      <= set_chip;
            pend_epoch     <= set_epoch;
            pend_sec       <= set_sec;
            pend_chip_max  <= set_chip_max;
            pend_epoch_max <= set_epoch_max;
        end else if (apply_sched) begin
            set_pending    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip      <= '0;
            epoch     <= '0;
            sec       <= '0;
            chip_max  <= CHIP_W'(CHIP_MAX_RST);
            epoch_max <= EPOCH_W'(EPOCH_MAX_RST);
        end else if (apply) begin
            chip      <= req_imm ? set_chip      : pend_chip;
            epoch     <= req_imm ? set_epoch     : pend_epoch;
            sec       <= req_imm ? set_sec       : pend_sec;
            chip_max  <= req_imm ? set_chip_max  : pend_chip_max;
            epoch_max <= req_imm ? set_epoch_max : pend_epoch_max;
        end else begin
            chip <= epoch_pulse ? '0 : chip + CHIP_W'(1);
            if (epoch_pulse)
                epoch <= sec_pulse ? '0 : epoch + EPOCH_W'(1);
            if (sec_pulse)
                sec <= week_pulse ? '0 : sec + SEC_W'(1);
        end
    end

    logic [26:0]          pps_cnt;
    logic [MIN_W-1:0]     pps_clk;
    logic [PPS_LEN_W-1:0] pps_ep;
    logic                 pps_start;
    logic                 pps_done;

    assign pps_start = (pps_cnt == pps_dly);
    assign pps_done  = (pps_len == '0)
                     ? (pps_clk == MIN_W'(PPS_MIN_CLK - 1))
                     : (epoch_pulse && pps_ep == pps_len - PPS_LEN_W'(1));

    // Delay counter tracks only true second boundaries, not loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            pps_cnt <= '0;
            pps_clk <= '0;
            pps_ep  <= '0;
            pps_out <= 1'b0;
        end else begin
            pps_cnt <= sec_pulse ? '0 : pps_cnt + 27'd1;
            if (pps_start) begin
                pps_out <= 1'b1;
                pps_clk <= '0;
                pps_ep  <= '0;
            end else if (pps_out) begin
                if (pps_done)
                    pps_out <= 1'b0;
                pps_clk <= pps_clk + MIN_W'(1);
                if (epoch_pulse)
                    pps_ep <= pps_ep + PPS_LEN_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_TRIG; i++) begin : g_cap
        ts_capture_ch #(
            .CHIP_W  (CHIP_W),
            .EPOCH_W (EPOCH_W),
            .SEC_W   (SEC_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .trig      (trig[i]),
            .trig_clr  (trig_clr[i]),
            .chip      (chip),
            .epoch     (epoch),
            .sec       (sec),
            .cap_valid (cap_valid[i]),
            .cap_ovf   (cap_ovf[i]),
            .cap_chip  (cap_chip[i*CHIP_W +: CHIP_W]),
            .cap_epoch (cap_epoch[i*EPOCH_W +: EPOCH_W]),
            .cap_sec   (cap_sec[i*SEC_W +: SEC_W])
        );
    end

endmodule

// File: tb/tb_time_scale_mtrig.sv
// Directed bench for time_scale_mtrig: counting, scheduled loads,
// capture channels, PPS timing and reset during activity.
module tb_time_scale_mtrig;

    localparam int CW = 20;
    localparam int EW = 10;
    localparam int SW = 20;
    localparam int NT = 4;
    localparam int LW = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              set_req;
    logic [1:0]        set_mode;
    logic [CW-1:0]     set_chip;
    logic [EW-1:0]     set_epoch;
    logic [SW-1:0]     set_sec;
    logic [CW-1:0]     set_chip_max;
    logic [EW-1:0]     set_epoch_max;
    logic              set_pending;
    logic [CW-1:0]     chip;
    logic [EW-1:0]     epoch;
    logic [SW-1:0]     sec;
    logic              epoch_pulse;
    logic              sec_pulse;
    logic              week_pulse;
    logic [NT-1:0]     trig;
    logic [NT-1:0]     trig_clr;
    logic [NT-1:0]     cap_valid;
    logic [NT-1:0]     cap_ovf;
    logic [NT*CW-1:0]  cap_chip;
    logic [NT*EW-1:0]  cap_epoch;
    logic [NT*SW-1:0]  cap_sec;
    logic [26:0]       pps_dly;
    logic [LW-1:0]     pps_len;
    logic              pps_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    time_scale_mtrig #(
        .CHIP_W        (CW),
        .EPOCH_W       (EW),
        .SEC_W         (SW),
        .SEC_WRAP      (3),
        .N_TRIG        (NT),
        .CHIP_MAX_RST  (15),
        .EPOCH_MAX_RST (3),
        .PPS_LEN_W     (LW),
        .PPS_MIN_CLK   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .set_req       (set_req),
        .set_mode      (set_mode),
        .set_chip      (set_chip),
        .set_epoch     (set_epoch),
        .set_sec       (set_sec),
        .set_chip_max  (set_chip_max),
        .set_epoch_max (set_epoch_max),
        .set_pending   (set_pending),
        .chip          (chip),
        .epoch         (epoch),
        .sec           (sec),
        .epoch_pulse   (epoch_pulse),
        .sec_pulse     (sec_pulse),
        .week_pulse    (week_pulse),
        .trig          (trig),
        .trig_clr      (trig_clr),
        .cap_valid     (cap_valid),
        .cap_ovf       (cap_ovf),
        .cap_chip      (cap_chip),
        .cap_epoch     (cap_epoch),
        .cap_sec       (cap_sec),
        .pps_dly       (pps_dly),
        .pps_len       (pps_len),
        .pps_out       (pps_out)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_set(input logic [1:0] m, input logic [CW-1:0] c,
                          input logic [EW-1:0] e, input logic [SW-1:0] s,
                          input logic [CW-1:0] cm, input logic [EW-1:0] em);
        set_req = 1'b1;
        set_mode = m;
        set_chip = c;
        set_epoch = e;
        set_sec = s;
        set_chip_max = cm;
        set_epoch_max = em;
        tick(1);
        set_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if ({chip, epoch, sec} !== '0) begin
            n_bad++;
            $display("FAIL reset_time: got %h/%h/%h want 0/0/0", chip, epoch, sec);
        end
        n_cmp++;
        if ({set_pending, cap_valid, cap_ovf, pps_out, epoch_pulse} !== '0) begin
            n_bad++;
            $display("FAIL reset_flags: pend=%b val=%b ovf=%b pps=%b ep=%b want all 0",
                     set_pending, cap_valid, cap_ovf, pps_out, epoch_pulse);
        end
        n_cmp++;
        if ({cap_chip, cap_epoch, cap_sec} !== '0) begin
            n_bad++;
            $display("FAIL reset_cap: got %h want 0", {cap_chip, cap_epoch, cap_sec});
        end
        rst = 1'b0;
        tick(15);
        n_cmp++;
        if ({chip, epoch_pulse, sec_pulse} !== {20'd15, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_chip_max: chip=%0d ep=%b sp=%b want 15/1/0",
                     chip, epoch_pulse, sec_pulse);
        end
        tick(1);
        n_cmp++;
        if ({chip, epoch} !== {20'd0, 10'd1}) begin
            n_bad++;
            $display("FAIL reset_wrap: chip=%0d epoch=%0d want 0/1", chip, epoch);
        end
    endtask

    task automatic test_counting();
        int ep_n = 0;
        int sp_n = 0;
        int first_ep = -1;
        int wk_n = 0;
        int wk_at = -1;
        do_set(2'd0, 20'd0, 10'd0, 20'd0, 20'd9, 10'd2);
        for (int i = 0; i < 60; i++) begin
            if (epoch_pulse) begin
                ep_n++;
                if (first_ep < 0) first_ep = i;
            end
            if (sec_pulse) sp_n++;
            tick(1);
        end
        n_cmp++;
        if (ep_n !== 6 || first_ep !== 9) begin
            n_bad++;
            $display("FAIL count_epoch: n=%0d first=%0d want 6/9", ep_n, first_ep);
        end
        n_cmp++;
        if (sp_n !== 2) begin
            n_bad++;
            $display("FAIL count_sec_pulse: got %0d want 2", sp_n);
        end
        n_cmp++;
        if ({chip, epoch, sec} !== {20'd0, 10'd0, 20'd2}) begin
            n_bad++;
            $display("FAIL count_time60: got %0d/%0d/%0d want 0/0/2", chip, epoch, sec);
        end
        for (int i = 60; i < 90; i++) begin
            if (week_pulse) begin
                wk_n++;
                wk_at = i;
            end
            tick(1);
        end
        n_cmp++;
        if (wk_n !== 1 || wk_at !== 89) begin
            n_bad++;
            $display("FAIL week_pulse: n=%0d at=%0d want 1/89", wk_n, wk_at);
        end
        n_cmp++;
        if ({chip, epoch, sec} !== '0) begin
            n_bad++;
            $display("FAIL week_wrap: got %0d/%0d/%0d want 0/0/0", chip, epoch, sec);
        end
    endtask

    task automatic test_mode1();
        tick(3);
        do_set(2'd1, 20'd5, 10'd1, 20'd0, 20'd9, 10'd2);
        n_cmp++;
        if ({chip, set_pending} !== {20'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL m1_pending: chip=%0d pend=%b want 4/1", chip, set_pending);
        end
        tick(5);
        n_cmp++;
        if ({chip, epoch, epoch_pulse, set_pending} !== {20'd9, 10'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL m1_wait: chip=%0d ep=%0d epp=%b pend=%b want 9/0/1/1",
                     chip, epoch, epoch_pulse, set_pending);
        end
        tick(1);
        n_cmp++;
        if ({chip, epoch, sec, set_pending} !== {20'd5, 10'd1, 20'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL m1_apply: got %0d/%0d/%0d pend=%b want 5/1/0 pend=0",
                     chip, epoch, sec, set_pending);
        end
        tick(4);
        do_set(2'd1, 20'd2, 10'd0, 20'd0, 20'd9, 10'd2);
        n_cmp++;
        if ({chip, epoch, set_pending} !== {20'd0, 10'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL m1_same_strobe: chip=%0d ep=%0d pend=%b want 0/2/1",
                     chip, epoch, set_pending);
        end
        tick(10);
        n_cmp++;
        if ({chip, epoch, sec, set_pending} !== {20'd2, 10'd0, 20'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL m1_apply_over_wrap: got %0d/%0d/%0d pend=%b want 2/0/0 pend=0",
                     chip, epoch, sec, set_pending);
        end
    endtask

    task automatic test_mode2();
        do_set(2'd2, 20'd0, 10'd0, 20'd50, 20'd9, 10'd2);
        n_cmp++;
        if ({chip, set_pending} !== {20'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL m2_pending: chip=%0d pend=%b want 3/1", chip, set_pending);
        end
        tick(2);
        do_set(2'd2, 20'd0, 10'd0, 20'd100, 20'd9, 10'd2);
        tick(3);
        tick(1);
        n_cmp++;
        if ({chip, epoch, set_pending} !== {20'd0, 10'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL m2_skip_epoch: chip=%0d ep=%0d pend=%b want 0/1/1",
                     chip, epoch, set_pending);
        end
        tick(19);
        n_cmp++;
        if (sec_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL m2_sec_pulse: got %b want 1", sec_pulse);
        end
        tick(1);
        n_cmp++;
        if ({chip, epoch, sec, set_pending} !== {20'd0, 10'd0, 20'd100, 1'b0}) begin
            n_bad++;
            $display("FAIL m2_apply: got %0d/%0d/%0d pend=%b want 0/0/100 pend=0",
                     chip, epoch, sec, set_pending);
        end
        do_set(2'd2, 20'd0, 10'd0, 20'd7, 20'd9, 10'd2);
        do_set(2'd0, 20'd4, 10'd1, 20'd20, 20'd9, 10'd2);
        n_cmp++;
        if ({chip, epoch, sec, set_pending} !== {20'd4, 10'd1, 20'd20, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_cancel: got %0d/%0d/%0d pend=%b want 4/1/20 pend=0",
                     chip, epoch, sec, set_pending);
        end
        tick(16);
        n_cmp++;
        if ({chip, epoch, sec, set_pending} !== {20'd0, 10'd0, 20'd21, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_no_late_apply: got %0d/%0d/%0d pend=%b want 0/0/21 pend=0",
                     chip, epoch, sec, set_pending);
        end
    endtask

    task automatic test_capture();
        do_set(2'd0, 20'd0, 10'd1, 20'd0, 20'd9, 10'd2);
        tick(4);
        trig = 4'b0010;
        tick(1);
        trig = 4'b0000;
        n_cmp++;
        if ({cap_valid, cap_ovf, cap_sec[SW +: SW], cap_epoch[EW +: EW], cap_chip[CW +: CW]}
            !== {4'b0010, 4'b0000, 20'd0, 10'd1, 20'd4}) begin
            n_bad++;
            $display("FAIL cap_first: val=%b ovf=%b t=%0d/%0d/%0d want 0010/0000 0/1/4",
                     cap_valid, cap_ovf, cap_sec[SW +: SW], cap_epoch[EW +: EW],
                     cap_chip[CW +: CW]);
        end
        trig = 4'b0010;
        tick(1);
        trig = 4'b0000;
        n_cmp++;
        if ({cap_valid, cap_ovf, cap_chip[CW +: CW]} !== {4'b0010, 4'b0010, 20'd4}) begin
            n_bad++;
            $display("FAIL cap_ovf: val=%b ovf=%b chip=%0d want 0010/0010/4",
                     cap_valid, cap_ovf, cap_chip[CW +: CW]);
        end
        tick(1);
        trig = 4'b0010;
        trig_clr = 4'b0010;
        tick(1);
        trig = 4'b0000;
        n_cmp++;
        if ({cap_valid, cap_ovf, cap_epoch[EW +: EW], cap_chip[CW +: CW]}
            !== {4'b0010, 4'b0000, 10'd1, 20'd7}) begin
            n_bad++;
            $display("FAIL cap_clr_trig: val=%b ovf=%b ep=%0d chip=%0d want 0010/0000/1/7",
                     cap_valid, cap_ovf, cap_epoch[EW +: EW], cap_chip[CW +: CW]);
        end
        n_cmp++;
        if ({cap_chip[0 +: CW], cap_chip[2*CW +: 2*CW]} !== '0) begin
            n_bad++;
            $display("FAIL cap_isolation: other chips=%h want 0",
                     {cap_chip[0 +: CW], cap_chip[2*CW +: 2*CW]});
        end
        tick(1);
        trig_clr = 4'b0000;
        n_cmp++;
        if ({cap_valid, cap_ovf} !== 8'h00) begin
            n_bad++;
            $display("FAIL cap_clear: val=%b ovf=%b want 0000/0000", cap_valid, cap_ovf);
        end
        trig = 4'b1001;
        tick(1);
        trig = 4'b0000;
        n_cmp++;
        if ({cap_valid, cap_ovf, cap_chip[3*CW +: CW], cap_epoch[0 +: EW]}
            !== {4'b1001, 4'b0000, 20'd9, 10'd1}) begin
            n_bad++;
            $display("FAIL cap_multi: val=%b ovf=%b ch3=%0d ep0=%0d want 1001/0000/9/1",
                     cap_valid, cap_ovf, cap_chip[3*CW +: CW], cap_epoch[0 +: EW]);
        end
    endtask

    task automatic test_pps();
        int k = 0;
        int hi = 0;
        int first = -1;
        int last = -1;
        pps_dly = 27'd5;
        pps_len = '0;
        while (!sec_pulse && k < 100) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (sec_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL pps_sync: no sec_pulse in %0d clk", k);
        end
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (pps_out) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (first !== 7 || hi !== 8) begin
            n_bad++;
            $display("FAIL pps_min: rise=%0d high=%0d want 7/8", first, hi);
        end
        pps_len = 7'd2;
        tick(6);
        n_cmp++;
        if (sec_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL pps_sec2: sec_pulse=%b want 1", sec_pulse);
        end
        hi = 0;
        first = -1;
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (pps_out) begin
                hi++;
                last = i;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (first !== 7 || last !== 20 || hi !== 14) begin
            n_bad++;
            $display("FAIL pps_len2: rise=%0d last=%0d high=%0d want 7/20/14",
                     first, last, hi);
        end
    endtask

    task automatic test_reset_mid();
        tick(6);
        tick(8);
        n_cmp++;
        if (pps_out !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pps_active: got %b want 1", pps_out);
        end
        do_set(2'd1, 20'd3, 10'd1, 20'd0, 20'd20, 10'd5);
        n_cmp++;
        if (set_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pending: got %b want 1", set_pending);
        end
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({chip, epoch, sec, set_pending, pps_out, cap_valid, cap_ovf} !== '0) begin
            n_bad++;
            $display("FAIL rm_reset: t=%0d/%0d/%0d pend=%b pps=%b val=%b ovf=%b want 0",
                     chip, epoch, sec, set_pending, pps_out, cap_valid, cap_ovf);
        end
        tick(1);
        rst = 1'b0;
        tick(15);
        n_cmp++;
        if ({chip, epoch_pulse, set_pending} !== {20'd15, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rm_max_default: chip=%0d ep=%b pend=%b want 15/1/0",
                     chip, epoch_pulse, set_pending);
        end
        tick(1);
        n_cmp++;
        if ({chip, epoch} !== {20'd0, 10'd1}) begin
            n_bad++;
            $display("FAIL rm_no_apply: chip=%0d ep=%0d want 0/1", chip, epoch);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_req = 1'b0;
        set_mode = 2'd0;
        set_chip = '0;
        set_epoch = '0;
        set_sec = '0;
        set_chip_max = '0;
        set_epoch_max = '0;
        trig = '0;
        trig_clr = '0;
        pps_dly = 27'h7FF_FFFF;
        pps_len = '0;
        test_reset();
        test_counting();
        test_mode1();
        test_mode2();
        test_capture();
        test_pps();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
